regfile_write_demux: RTL and testbench
======================================

# regfile_write_demux

Write side of the eight-register register file: accepts write requests, decodes the 3-bit register address into a one-hot write enable, and updates one of eight 8-bit storage registers. All eight registers are exported flat, so external 8-to-1 read multiplexers can select any of them. An address-sweep state machine zeroes the file after reset and on request.

## Interface
- `W`, default 8: data width per register.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: write accepted when `wr_valid && wr_ready` at a rising edge.
- `wr_addr` in 3: target register 0..7.
- `wr_data` in W: write data.
- `clr` in 1: one-cycle pulse that starts a zeroing sweep.
- `wr_bcast` in 1: broadcast write, only present with `REGFILE_BCAST_EN`.
- `wr_en_onehot` out 8: registered decoded write enable of the commit stage.
- `wr_ack` out 1: one-cycle pulse when a user write has committed.
- `busy` out 1: a sweep is in progress or sweep writes are still in the stage.
- `q_flat` out 8*W: register r at bits [r*W +: W].

## Operation
- State machine has two states, CLEAR and IDLE, plus a 3-bit sweep counter `cnt`.
- Reset: state=CLEAR, cnt=0, stage empty.
  - Reset values: `wr_ready`=0, `busy`=1, `wr_ack`=0, `wr_en_onehot`=0.
  - `q_flat` is not reset; it is undefined until the sweep completes, then all zero.
- CLEAR:
  - Each cycle, load the stage with addr=cnt, data=0, tagged as a sweep write; cnt increments.
  - After the cnt=7 issue, go to IDLE.
  - `wr_ready`=0.
- IDLE:
  - `wr_ready`=1.
  - An accepted request loads the stage with addr/data, tagged as a user write.
  - `clr`=1 moves to CLEAR next cycle with cnt=0.
- Stage:
  - Decodes addr into `wr_en_onehot`, exactly one bit set when occupied, otherwise 0.
  - Commits on the following edge: reg[addr] <= data.
  - `wr_ack`=1 for the cycle after a user-write commit; sweep commits never assert `wr_ack`.
- Throughput is one write per cycle. Back-to-back writes to the same address: the last one wins.
- `clr` and an accepted write in the same IDLE cycle: the write commits first, then the sweep zeroes it. Final register value is 0 and `wr_ack` still pulses.
- `clr` during CLEAR: cnt restarts at 0.
- `rst` mid-sweep or mid-write: any stage contents are discarded (no commit, no ack) and the sweep restarts.
- `busy` = (state==CLEAR) || (stage holds a sweep write).

## Timing
- Reset sampled at edge R: sweep addresses 0..7 are issued at edges R+1..R+8 and committed at R+2..R+9.
- `wr_ready` rises after edge R+8.
- `busy` falls after edge R+9.
- User write accepted at edge E:
  - `wr_en_onehot` valid after E.
  - Register visible on `q_flat` after E+1.
  - `wr_ack` high between E+1 and E+2.
- `clr` sampled at edge C in IDLE: `wr_ready` low after C; the 8-cycle sweep follows the same timing as after reset.

## Configuration
- `REGFILE_BCAST_EN` defined:
  - Port `wr_bcast` exists.
  - An accepted write with `wr_bcast`=1 sets `wr_en_onehot`=8'hFF, ignores `wr_addr`, and writes `wr_data` to all eight registers.
  - One `wr_ack` per broadcast.
- Undefined: the port is absent and only single-register writes exist.

## Test plan
- Reset, then idle: `wr_ready`=0 for 8 cycles, `busy` falls after edge R+9, `q_flat`=0, no `wr_ack`.
- Write addr=5, data=8'hA7: `wr_en_onehot`=8'h20 for one cycle, `q_flat[47:40]`=8'hA7 after 2 edges, `wr_ack` pulses once; other registers unchanged.
- Eight back-to-back writes, addr r with data 8'h10+r: one `wr_ack` per cycle, final `q_flat`=64'h1716151413121110.
- Write addr=3 data=8'h55 in the same cycle as `clr`: `wr_ack` pulses once, `wr_ready`=0 for 8 cycles, register 3 ends at 0.
- Assert `rst` during the sweep at cnt=4, and separately during a pending write: the sweep restarts at address 0, the pending write is dropped with no `wr_ack`, and the file is all zero afterwards.
- With `REGFILE_BCAST_EN`, broadcast 8'h3C: `wr_en_onehot`=8'hFF, `q_flat`=64'h3C3C3C3C3C3C3C3C, exactly one `wr_ack`.

Source files
------------

// File: rtl/regfile_write_demux.sv
// Write side of an 8-entry register file: one-hot decoded commit stage plus a zeroing sweep FSM.
// Optional broadcast writes are enabled by defining REGFILE_BCAST_EN.

module regfile_cell #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Storage is intentionally not reset; the post-reset sweep zeroes it.
  always_ff @(posedge clk) begin
    if (!rst && en) q <= d;
  end
endmodule

module regfile_write_demux #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [2:0]     wr_addr,
  input  logic [W-1:0]   wr_data,
  input  logic           clr,
`ifdef REGFILE_BCAST_EN
  input  logic           wr_bcast,
`endif
  output logic [7:0]     wr_en_onehot,
  output logic           wr_ack,
  output logic           busy,
  output logic [8*W-1:0] q_flat
);
  typedef enum logic {CLEAR, IDLE} state_t;

  typedef struct packed {
    logic         vld;
    logic         sweep;
    logic [7:0]   en;
    logic [W-1:0] data;
  } stage_t;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  stage_t     stg, stg_nxt;
  logic       bcast;

`ifdef REGFILE_BCAST_EN
  assign bcast = wr_bcast;
`else
  assign bcast = 1'b0;
`endif

  assign wr_ready     = (state == IDLE);
  assign wr_en_onehot = stg.en;
  assign busy         = (state == CLEAR) || (stg.vld && stg.sweep);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stg_nxt   = '0;
    case (state)
      CLEAR: begin
        stg_nxt.vld   = 1'b1;
        stg_nxt.sweep = 1'b1;
        stg_nxt.en    = 8'(1) << cnt;
        cnt_nxt       = cnt + 3'd1;
        if (clr)             cnt_nxt   = 3'd0;
        else if (cnt == 3'd7) state_nxt = IDLE;
      end
      IDLE: begin
        if (wr_valid) begin
          stg_nxt.vld  = 1'b1;
          stg_nxt.en   = bcast ? 8'hFF : (8'(1) << wr_addr);
          stg_nxt.data = wr_data;
        end
        // A write accepted alongside clr commits first; the sweep then zeroes it.
        if (clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = 3'd0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CLEAR;
      cnt    <= 3'd0;
      stg    <= '0;
      wr_ack <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      stg    <= stg_nxt;
      wr_ack <= stg.vld && !stg.sweep;
    end
  end

  for (genvar r = 0; r < 8; r++) begin : g_cell
    regfile_cell #(.W(W)) u_cell (
      .clk (clk),
      .rst (rst),
      .en  (stg.en[r]),
      .d   (stg.data),
      .q   (q_flat[r*W +: W])
    );
  end
endmodule

// File: tb/tb_regfile_write_demux.sv
// Directed self-checking bench for regfile_write_demux (default 8-bit width).

module tb_regfile_write_demux;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_addr = 3'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        clr = 1'b0;
`ifdef REGFILE_BCAST_EN
  logic        wr_bcast = 1'b0;
`endif
  logic [7:0]  wr_en_onehot;
  logic        wr_ack;
  logic        busy;
  logic [63:0] q_flat;

  int checks = 0;
  int errors = 0;

  regfile_write_demux #(.W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .clr          (clr),
`ifdef REGFILE_BCAST_EN
    .wr_bcast     (wr_bcast),
`endif
    .wr_en_onehot (wr_en_onehot),
    .wr_ack       (wr_ack),
    .busy         (busy),
    .q_flat       (q_flat)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset at edge R, then full sweep to R+9.
  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", wr_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b exp 1", busy); end
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b exp 0", wr_ack); end
    checks++; if (wr_en_onehot !== 8'h00) begin errors++; $display("FAIL reset_en: got %h exp 00", wr_en_onehot); end
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++; if (wr_en_onehot !== (8'h01 << (i-1))) begin errors++; $display("FAIL sweep_en[%0d]: got %h exp %h", i, wr_en_onehot, 8'h01 << (i-1)); end
      checks++; if (wr_ready !== (i == 8)) begin errors++; $display("FAIL sweep_ready[%0d]: got %b exp %b", i, wr_ready, i == 8); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sweep_busy[%0d]: got %b exp 1", i, busy); end
      checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL sweep_ack[%0d]: got %b exp 0", i, wr_ack); end
    end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sweep_busy_end: got %b exp 0", busy); end
    checks++; if (q_flat !== 64'h0) begin errors++; $display("FAIL sweep_q: got %h exp 0", q_flat); end
  endtask

  task automatic test_single_write();
    wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 8'hA7;
    step();
    wr_valid = 1'b0;
    checks++; if (wr_en_onehot !== 8'h20) begin errors++; $display("FAIL wr_en: got %h exp 20", wr_en_onehot); end
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_early: got %b exp 0", wr_ack); end
    step();
    checks++; if (q_flat !== 64'h0000_A700_0000_0000) begin errors++; $display("FAIL wr_q: got %h exp 0000a70000000000", q_flat); end
    checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL wr_ack: got %b exp 1", wr_ack); end
    checks++; if (wr_en_onehot !== 8'h00) begin errors++; $display("FAIL wr_en_clear: got %h exp 00", wr_en_onehot); end
    step();
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_once: got %b exp 0", wr_ack); end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    for (int r = 0; r < 8; r++) begin
      wr_valid = 1'b1; wr_addr = 3'(r); wr_data = 8'h10 + 8'(r);
      step();
      checks++; if (wr_en_onehot !== (8'h01 << r)) begin errors++; $display("FAIL b2b_en[%0d]: got %h exp %h", r, wr_en_onehot, 8'h01 << r); end
      if (wr_ack) acks++;
    end
    wr_valid = 1'b0;
    step();
    if (wr_ack) acks++;
    step();
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_tail: got %b exp 0", wr_ack); end
    checks++; if (acks != 8) begin errors++; $display("FAIL b2b_acks: got %0d exp 8", acks); end
    checks++; if (q_flat !== 64'h1716151413121110) begin errors++; $display("FAIL b2b_q: got %h exp 1716151413121110", q_flat); end
  endtask

  task automatic test_write_with_clr();
    int acks = 0;
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 8'h55; clr = 1'b1;
    step();
    wr_valid = 1'b0; clr = 1'b0;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL clr_ready: got %b exp 0", wr_ready); end
    checks++; if (wr_en_onehot !== 8'h08) begin errors++; $display("FAIL clr_en: got %h exp 08", wr_en_onehot); end
    step();
    checks++; if (q_flat[31:24] !== 8'h55) begin errors++; $display("FAIL clr_commit: got %h exp 55", q_flat[31:24]); end
    checks++; if (wr_en_onehot !== 8'h01) begin errors++; $display("FAIL clr_sweep0: got %h exp 01", wr_en_onehot); end
    if (wr_ack) acks++;
    for (int i = 2; i <= 8; i++) begin
      step();
      if (wr_ack) acks++;
      checks++; if (wr_ready !== (i == 8)) begin errors++; $display("FAIL clr_ready[%0d]: got %b exp %b", i, wr_ready, i == 8); end
    end
    step();
    if (wr_ack) acks++;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy_end: got %b exp 0", busy); end
    checks++; if (acks != 1) begin errors++; $display("FAIL clr_acks: got %0d exp 1", acks); end
    checks++; if (q_flat !== 64'h0) begin errors++; $display("FAIL clr_q: got %h exp 0", q_flat); end
  endtask

  task automatic test_reset_mid_sweep();
    wr_valid = 1'b1; wr_addr = 3'd6; wr_data = 8'h99;
    step();
    wr_valid = 1'b0;
    step();
    checks++; if (q_flat[55:48] !== 8'h99) begin errors++; $display("FAIL rs_pre: got %h exp 99", q_flat[55:48]); end
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (wr_en_onehot !== 8'h00) begin errors++; $display("FAIL rs_en: got %h exp 00", wr_en_onehot); end
    step();
    checks++; if (wr_en_onehot !== 8'h01) begin errors++; $display("FAIL rs_restart: got %h exp 01", wr_en_onehot); end
    for (int i = 2; i <= 9; i++) step();
    checks++; if (busy !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL rs_done: got busy=%b ready=%b exp 0/1", busy, wr_ready); end
    checks++; if (q_flat !== 64'h0) begin errors++; $display("FAIL rs_q: got %h exp 0", q_flat); end
  endtask

  task automatic test_reset_pending_write();
    int acks = 0;
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 8'hEE;
    step();
    wr_valid = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (q_flat[23:16] !== 8'h00) begin errors++; $display("FAIL rp_drop: got %h exp 00", q_flat[23:16]); end
    checks++; if (wr_en_onehot !== 8'h00) begin errors++; $display("FAIL rp_en: got %h exp 00", wr_en_onehot); end
    for (int i = 1; i <= 9; i++) begin
      if (wr_ack) acks++;
      step();
    end
    if (wr_ack) acks++;
    checks++; if (acks != 0) begin errors++; $display("FAIL rp_acks: got %0d exp 0", acks); end
    checks++; if (q_flat !== 64'h0) begin errors++; $display("FAIL rp_q: got %h exp 0", q_flat); end
  endtask

`ifdef REGFILE_BCAST_EN
  task automatic test_bcast();
    wr_valid = 1'b1; wr_bcast = 1'b1; wr_addr = 3'd1; wr_data = 8'h3C;
    step();
    wr_valid = 1'b0; wr_bcast = 1'b0;
    checks++; if (wr_en_onehot !== 8'hFF) begin errors++; $display("FAIL bc_en: got %h exp ff", wr_en_onehot); end
    step();
    checks++; if (q_flat !== 64'h3C3C3C3C3C3C3C3C) begin errors++; $display("FAIL bc_q: got %h exp 3c3c3c3c3c3c3c3c", q_flat); end
    checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL bc_ack: got %b exp 1", wr_ack); end
    step();
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL bc_ack_once: got %b exp 0", wr_ack); end
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_write_with_clr();
    test_reset_mid_sweep();
    test_reset_pending_write();
`ifdef REGFILE_BCAST_EN
    test_bcast();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
